// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA/debug port.
// Default build: CPU priority with a starvation guard; define DMEM_ARB_RR_EN for strict round-robin.
module dmem_arbiter #(
    parameter int WORD_W     = 64,
    parameter int DEPTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [WORD_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [WORD_W-1:0] cpu_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [WORD_W-1:0] dma_addr_i,
    input  logic [WORD_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [WORD_W-1:0] dma_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [WORD_W-1:0] mem_address_o,
    output logic [WORD_W-1:0] mem_write_data_o,
    input  logic [WORD_W-1:0] mem_read_data_i,
    output logic              addr_err_o
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    state_t            state_q;
    logic              mem_read_q, mem_write_q, addr_err_q;
    logic [WORD_W-1:0] mem_address_q, mem_write_data_q;
    logic              rd1_vld_q, rd1_oor_q;
    logic              rd2_vld_q, rd2_oor_q, rd2_dma_q;
    logic [WORD_W-1:0] cpu_rdata_q, dma_rdata_q;

`ifdef DMEM_ARB_RR_EN
    // rr_last_q: 0 = CPU granted last, 1 = DMA granted last
    logic rr_last_q, rr_last_d;

    always_comb begin
        cpu_gnt_o = cpu_req_i & (~dma_req_i | rr_last_q);
        dma_gnt_o = dma_req_i & (~cpu_req_i | ~rr_last_q);
        rr_last_d = rr_last_q;
        if (cpu_gnt_o)      rr_last_d = 1'b0;
        else if (dma_gnt_o) rr_last_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last_q <= 1'b0;
        else        rr_last_q <= rr_last_d;
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             dma_force;

    always_comb begin
        dma_force    = dma_req_i & (starve_cnt_q == CNT_W'(STARVE_MAX));
        cpu_gnt_o    = cpu_req_i & ~dma_force;
        dma_gnt_o    = dma_req_i & (~cpu_req_i | dma_force);
        starve_cnt_d = starve_cnt_q;
        if (dma_gnt_o)
            starve_cnt_d = '0;
        else if (dma_req_i && starve_cnt_q < CNT_W'(STARVE_MAX))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end
`endif

    logic              any_gnt, sel_we, sel_oor;
    logic [WORD_W-1:0] sel_addr, sel_wdata, ret_data;

    always_comb begin
        any_gnt   = cpu_gnt_o | dma_gnt_o;
        sel_we    = dma_gnt_o ? dma_we_i    : cpu_we_i;
        sel_addr  = dma_gnt_o ? dma_addr_i  : cpu_addr_i;
        sel_wdata = dma_gnt_o ? dma_wdata_i : cpu_wdata_i;
        sel_oor   = (sel_addr >> 3) >= WORD_W'(DEPTH);
        ret_data  = rd2_oor_q ? '0 : mem_read_data_i;
    end

    // state_q is the owner of the memory port this cycle and doubles as the slot-1 owner tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            addr_err_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            rd1_vld_q        <= 1'b0;
            rd1_oor_q        <= 1'b0;
            rd2_vld_q        <= 1'b0;
            rd2_oor_q        <= 1'b0;
            rd2_dma_q        <= 1'b0;
            cpu_rdata_q      <= '0;
            dma_rdata_q      <= '0;
        end else begin
            if (cpu_gnt_o)      state_q <= CPU_ACC;
            else if (dma_gnt_o) state_q <= DMA_ACC;
            else                state_q <= IDLE;
            mem_read_q       <= any_gnt & ~sel_we & ~sel_oor;
            mem_write_q      <= any_gnt & sel_we & ~sel_oor;
            addr_err_q       <= any_gnt & sel_oor;
            mem_address_q    <= any_gnt ? sel_addr : '0;
            mem_write_data_q <= (any_gnt && sel_we) ? sel_wdata : '0;
            rd1_vld_q        <= any_gnt & ~sel_we;
            rd1_oor_q        <= any_gnt & sel_oor;
            rd2_vld_q        <= rd1_vld_q;
            rd2_oor_q        <= rd1_oor_q;
            rd2_dma_q        <= (state_q == DMA_ACC);
            if (cpu_rvalid_o) cpu_rdata_q <= ret_data;
            if (dma_rvalid_o) dma_rdata_q <= ret_data;
        end
    end

    // Read data is muxed straight from memory on the return cycle and held afterwards.
    assign cpu_rvalid_o     = rd2_vld_q & ~rd2_dma_q;
    assign dma_rvalid_o     = rd2_vld_q & rd2_dma_q;
    assign cpu_rdata_o      = cpu_rvalid_o ? ret_data : cpu_rdata_q;
    assign dma_rdata_o      = dma_rvalid_o ? ret_data : dma_rdata_q;
    assign cpu_stall_o      = cpu_req_i & ~cpu_gnt_o;
    assign mem_read_o       = mem_read_q;
    assign mem_write_o      = mem_write_q;
    assign mem_address_o    = mem_address_q;
    assign mem_write_data_o = mem_write_data_q;
    assign addr_err_o       = addr_err_q;
endmodule
